// File: rtl/pong_pkg.sv
// Shared Pong engine types, geometry constants and the paddle step function.
// Combinational helpers only; no state, no flow control.
// Positions are widened to signed 11 bits so steps past an edge stay comparable.
package pong_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int PADDLE_H     = 80;
    localparam int PADDLE_W     = 10;
    localparam int PADDLE_X0    = 20;
    localparam int PADDLE_X1    = 610;
    localparam int BALL_SIZE    = 10;
    localparam int PADDLE_SPEED = 4;
    localparam int BALL_SPEED   = 2;
    localparam int SCORE_PAUSE  = 60;
    localparam int WIN_SCORE    = 9;

    localparam int WORK_W = 11;
    typedef logic signed [WORK_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_SCORED    = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam logic [9:0] BALL_X_C = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y_C = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PADDLE_C = 10'((V_ACTIVE - PADDLE_H) / 2);

    function automatic wide_t widen(input logic [9:0] v);
        return wide_t'({1'b0, v});
    endfunction

    function automatic logic [9:0] paddle_next(input logic [9:0] pos,
                                               input logic       up,
                                               input logic       dn);
        wide_t p;
        p = widen(pos);
        if (up && !dn) begin
            p = p - wide_t'(PADDLE_SPEED);
            if (p < wide_t'(0)) p = wide_t'(0);
        end else if (dn && !up) begin
            p = p + wide_t'(PADDLE_SPEED);
            if (p > wide_t'(V_ACTIVE - PADDLE_H)) p = wide_t'(V_ACTIVE - PADDLE_H);
        end
        return p[9:0];
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Single-bit two-flop synchronizer for a raw asynchronous button.
// Latency: 2 clk_pxl cycles. Backpressure: none, level passes straight through.
module btn_sync (
    input  logic clk_pxl,
    input  logic reset,
    input  logic btn_in,
    output logic btn_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_pxl or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_in;
            sync_q <= meta_q;
        end
    end

    assign btn_out = sync_q;

endmodule

// File: rtl/pong_game_logic.sv
// Pong frame engine: paddles, ball motion, wall/paddle/goal collisions, score.
// Latency: buttons 2 cycles to sync; outputs update 1 cycle after frame_tick.
// Backpressure: none; every frame_tick is a full update, registers hold otherwise.
module pong_game_logic
    import pong_pkg::*;
(
    input  logic       clk_pxl,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up0,
    input  logic       btn_dn0,
    input  logic       btn_up1,
    input  logic       btn_dn1,
    input  logic       btn_start,
    output logic [9:0] paddle0_pos,
    output logic [9:0] paddle1_pos,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [1:0] game_state
);

    localparam wide_t BSZ    = wide_t'(BALL_SIZE);
    localparam wide_t STEP   = wide_t'(BALL_SPEED);
    localparam wide_t PH     = wide_t'(PADDLE_H);
    localparam wide_t L_FACE = wide_t'(PADDLE_X0 + PADDLE_W);
    localparam wide_t R_FACE = wide_t'(PADDLE_X1);
    localparam wide_t X_LIM  = wide_t'(H_ACTIVE);
    localparam wide_t Y_LIM  = wide_t'(V_ACTIVE);
    localparam wide_t ZERO   = wide_t'(0);

    logic up0_s, dn0_s, up1_s, dn1_s, start_s;

    btn_sync u_sync_up0   (.clk_pxl(clk_pxl), .reset(reset), .btn_in(btn_up0),   .btn_out(up0_s));
    btn_sync u_sync_dn0   (.clk_pxl(clk_pxl), .reset(reset), .btn_in(btn_dn0),   .btn_out(dn0_s));
    btn_sync u_sync_up1   (.clk_pxl(clk_pxl), .reset(reset), .btn_in(btn_up1),   .btn_out(up1_s));
    btn_sync u_sync_dn1   (.clk_pxl(clk_pxl), .reset(reset), .btn_in(btn_dn1),   .btn_out(dn1_s));
    btn_sync u_sync_start (.clk_pxl(clk_pxl), .reset(reset), .btn_in(btn_start), .btn_out(start_s));

    logic [9:0]  paddle0_q, paddle0_d, paddle1_q, paddle1_d;
    logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [3:0]  score0_q, score0_d, score1_q, score1_d;
    game_state_t state_q, state_d;
    logic        dx_q, dx_d, dy_q, dy_d, loser_q, loser_d;
    logic [5:0]  pause_q, pause_d;

    wide_t bx, by, nx, ny, p0, p1;
    logic  hit_left, hit_right;

    // dx/dy: 1 means moving toward increasing x/y.
    assign bx = widen(ball_x_q);
    assign by = widen(ball_y_q);
    assign p0 = widen(paddle0_q);
    assign p1 = widen(paddle1_q);
    assign nx = dx_q ? bx + STEP : bx - STEP;
    assign ny = dy_q ? by + STEP : by - STEP;

    // Paddle overlap uses the pre-update paddle positions of this frame.
    assign hit_left  = !dx_q && (bx >= L_FACE) && (nx <= L_FACE)
                       && (by + BSZ > p0) && (by < p0 + PH);
    assign hit_right = dx_q && (bx + BSZ <= R_FACE) && (nx + BSZ >= R_FACE)
                       && (by + BSZ > p1) && (by < p1 + PH);

    always_comb begin
        paddle0_d = paddle0_q;
        paddle1_d = paddle1_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        score0_d  = score0_q;
        score1_d  = score1_q;
        state_d   = state_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        loser_d   = loser_q;
        pause_d   = pause_q;

        if (frame_tick) begin
            paddle0_d = paddle_next(paddle0_q, up0_s, dn0_s);
            paddle1_d = paddle_next(paddle1_q, up1_s, dn1_s);

            case (state_q)
                ST_SERVE: begin
                    if (start_s) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (ny < ZERO) begin
                        ball_y_d = 10'd0;
                        dy_d     = 1'b1;
                    end else if (ny + BSZ > Y_LIM) begin
                        ball_y_d = 10'(V_ACTIVE - BALL_SIZE);
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = ny[9:0];
                    end

                    if (hit_left) begin
                        ball_x_d = 10'(PADDLE_X0 + PADDLE_W);
                        dx_d     = 1'b1;
                    end else if (hit_right) begin
                        ball_x_d = 10'(PADDLE_X1 - BALL_SIZE);
                        dx_d     = 1'b0;
                    end else if (nx < ZERO) begin
                        ball_x_d = 10'd0;
                        score1_d = score1_q + 4'd1;
                        state_d  = ST_SCORED;
                        loser_d  = 1'b0;
                        pause_d  = 6'd0;
                    end else if (nx + BSZ > X_LIM) begin
                        ball_x_d = 10'(H_ACTIVE - BALL_SIZE);
                        score0_d = score0_q + 4'd1;
                        state_d  = ST_SCORED;
                        loser_d  = 1'b1;
                        pause_d  = 6'd0;
                    end else begin
                        ball_x_d = nx[9:0];
                    end
                end
                ST_SCORED: begin
                    if (pause_q == 6'(SCORE_PAUSE - 1)) begin
                        pause_d  = 6'd0;
                        ball_x_d = BALL_X_C;
                        ball_y_d = BALL_Y_C;
                        dx_d     = loser_q;
                        if (score0_q == 4'(WIN_SCORE) || score1_q == 4'(WIN_SCORE))
                            state_d = ST_GAME_OVER;
                        else
                            state_d = ST_PLAY;
                    end else begin
                        pause_d = pause_q + 6'd1;
                    end
                end
                ST_GAME_OVER: begin
                    if (start_s) begin
                        score0_d = 4'd0;
                        score1_d = 4'd0;
                        state_d  = ST_SERVE;
                    end
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    always_ff @(posedge clk_pxl or posedge reset) begin
        if (reset) begin
            paddle0_q <= PADDLE_C;
            paddle1_q <= PADDLE_C;
            ball_x_q  <= BALL_X_C;
            ball_y_q  <= BALL_Y_C;
            score0_q  <= 4'd0;
            score1_q  <= 4'd0;
            state_q   <= ST_SERVE;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            loser_q   <= 1'b0;
            pause_q   <= 6'd0;
        end else begin
            paddle0_q <= paddle0_d;
            paddle1_q <= paddle1_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            score0_q  <= score0_d;
            score1_q  <= score1_d;
            state_q   <= state_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            loser_q   <= loser_d;
            pause_q   <= pause_d;
        end
    end

    assign paddle0_pos = paddle0_q;
    assign paddle1_pos = paddle1_q;
    assign ball_pos_x  = ball_x_q;
    assign ball_pos_y  = ball_y_q;
    assign score0      = score0_q;
    assign score1      = score1_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_pong_game_logic.sv
// Directed bench for pong_game_logic: clamp, bounces, misses, pause, game over, reset.
// Expected positions are hand-traced frame counts from the centre serve.
module tb_pong_game_logic;

    logic       clk_pxl = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up0 = 1'b0, btn_dn0 = 1'b0, btn_up1 = 1'b0, btn_dn1 = 1'b0;
    logic       btn_start = 1'b0;
    logic [9:0] paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y;
    logic [3:0] score0, score1;
    logic [1:0] game_state;

    int total = 0;
    int bad = 0;

    pong_game_logic dut (
        .clk_pxl(clk_pxl), .reset(reset), .frame_tick(frame_tick),
        .btn_up0(btn_up0), .btn_dn0(btn_dn0), .btn_up1(btn_up1), .btn_dn1(btn_dn1),
        .btn_start(btn_start),
        .paddle0_pos(paddle0_pos), .paddle1_pos(paddle1_pos),
        .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
        .score0(score0), .score1(score1), .game_state(game_state)
    );

    always #5 clk_pxl = ~clk_pxl;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_pxl);
            frame_tick = 1'b1;
            @(negedge clk_pxl);
            frame_tick = 1'b0;
        end
    endtask

    task automatic set_btns(input logic u0, input logic d0, input logic u1,
                            input logic d1, input logic st);
        btn_up0 = u0; btn_dn0 = d0; btn_up1 = u1; btn_dn1 = d1; btn_start = st;
        repeat (3) @(negedge clk_pxl);
    endtask

    task automatic do_reset();
        @(negedge clk_pxl);
        reset = 1'b1;
        repeat (2) @(negedge clk_pxl);
        reset = 1'b0;
        repeat (2) @(negedge clk_pxl);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_pxl);
        total++;
        if ({paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y, score0, score1, game_state}
            !== {10'd200, 10'd200, 10'd315, 10'd235, 4'd0, 4'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_values: got p0=%0d p1=%0d x=%0d y=%0d s=%0d/%0d st=%0d want 200 200 315 235 0/0 0",
                     paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y, score0, score1, game_state);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk_pxl);
        ticks(3);
        total++;
        if ({paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y, game_state}
            !== {10'd200, 10'd200, 10'd315, 10'd235, 2'd0}) begin
            bad++;
            $display("FAIL idle_frames: got p0=%0d p1=%0d x=%0d y=%0d st=%0d want 200 200 315 235 0",
                     paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y, game_state);
        end
    endtask

    task automatic test_paddle_clamp();
        set_btns(1, 1, 0, 0, 0);
        ticks(3);
        total++;
        if (paddle0_pos !== 10'd200) begin
            bad++; $display("FAIL both_buttons_hold: got %0d want 200", paddle0_pos);
        end
        set_btns(1, 0, 0, 0, 0);
        ticks(1);
        total++;
        if (paddle0_pos !== 10'd196) begin
            bad++; $display("FAIL paddle0_up_step: got %0d want 196", paddle0_pos);
        end
        ticks(59);
        total++;
        if ({paddle0_pos, paddle1_pos, game_state} !== {10'd0, 10'd200, 2'd0}) begin
            bad++; $display("FAIL paddle0_top_clamp: got p0=%0d p1=%0d st=%0d want 0 200 0",
                            paddle0_pos, paddle1_pos, game_state);
        end
        set_btns(0, 0, 0, 1, 0);
        ticks(1);
        total++;
        if (paddle1_pos !== 10'd204) begin
            bad++; $display("FAIL paddle1_dn_step: got %0d want 204", paddle1_pos);
        end
        ticks(59);
        total++;
        if ({paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y} !== {10'd0, 10'd400, 10'd315, 10'd235}) begin
            bad++; $display("FAIL paddle1_bottom_clamp: got p0=%0d p1=%0d x=%0d y=%0d want 0 400 315 235",
                            paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y);
        end
        set_btns(0, 0, 0, 0, 0);
    endtask

    // Serve right, bottom wall, paddle1 at 400 returns it, paddle0 moved to 100 returns it again.
    task automatic test_paddle_bounce();
        set_btns(0, 0, 0, 0, 1);
        ticks(1);
        total++;
        if ({game_state, ball_pos_x, ball_pos_y} !== {2'd1, 10'd315, 10'd235}) begin
            bad++; $display("FAIL serve_start: got st=%0d x=%0d y=%0d want 1 315 235",
                            game_state, ball_pos_x, ball_pos_y);
        end
        set_btns(0, 0, 0, 0, 0);
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd317, 10'd237}) begin
            bad++; $display("FAIL first_step: got (%0d,%0d) want (317,237)", ball_pos_x, ball_pos_y);
        end
        ticks(116);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd549, 10'd469}) begin
            bad++; $display("FAIL before_bottom: got (%0d,%0d) want (549,469)", ball_pos_x, ball_pos_y);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd551, 10'd470}) begin
            bad++; $display("FAIL bottom_clamp: got (%0d,%0d) want (551,470)", ball_pos_x, ball_pos_y);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd553, 10'd468}) begin
            bad++; $display("FAIL bottom_rebound: got (%0d,%0d) want (553,468)", ball_pos_x, ball_pos_y);
        end
        ticks(24);
        total++;
        if ({ball_pos_x, ball_pos_y, score0} !== {10'd600, 10'd420, 4'd0}) begin
            bad++; $display("FAIL right_paddle_hit: got (%0d,%0d) s0=%0d want (600,420) 0",
                            ball_pos_x, ball_pos_y, score0);
        end
        set_btns(0, 1, 0, 0, 0);
        ticks(25);
        total++;
        if ({paddle0_pos, ball_pos_x, ball_pos_y} !== {10'd100, 10'd550, 10'd370}) begin
            bad++; $display("FAIL leftward_flight: got p0=%0d (%0d,%0d) want 100 (550,370)",
                            paddle0_pos, ball_pos_x, ball_pos_y);
        end
        set_btns(0, 0, 0, 0, 0);
        ticks(259);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd32, 10'd146}) begin
            bad++; $display("FAIL left_approach: got (%0d,%0d) want (32,146)", ball_pos_x, ball_pos_y);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd30, 10'd148}) begin
            bad++; $display("FAIL left_paddle_hit: got (%0d,%0d) want (30,148)", ball_pos_x, ball_pos_y);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y, score0, score1, game_state} !== {10'd32, 10'd150, 4'd0, 4'd0, 2'd1}) begin
            bad++; $display("FAIL left_rebound: got (%0d,%0d) s=%0d/%0d st=%0d want (32,150) 0/0 1",
                            ball_pos_x, ball_pos_y, score0, score1, game_state);
        end
    endtask

    task automatic test_miss();
        do_reset();
        set_btns(1, 0, 0, 1, 0);
        ticks(60);
        set_btns(0, 0, 0, 0, 1);
        ticks(1);
        set_btns(0, 0, 0, 0, 0);
        ticks(443);
        total++;
        if ({ball_pos_x, ball_pos_y, score1, game_state} !== {10'd0, 10'd178, 4'd0, 2'd1}) begin
            bad++; $display("FAIL left_edge_reach: got (%0d,%0d) s1=%0d st=%0d want (0,178) 0 1",
                            ball_pos_x, ball_pos_y, score1, game_state);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y, score0, score1, game_state} !== {10'd0, 10'd180, 4'd0, 4'd1, 2'd2}) begin
            bad++; $display("FAIL left_goal: got (%0d,%0d) s=%0d/%0d st=%0d want (0,180) 0/1 2",
                            ball_pos_x, ball_pos_y, score0, score1, game_state);
        end
        set_btns(0, 0, 0, 0, 1);
        ticks(10);
        total++;
        if ({ball_pos_x, ball_pos_y, game_state} !== {10'd0, 10'd180, 2'd2}) begin
            bad++; $display("FAIL start_ignored_scored: got (%0d,%0d) st=%0d want (0,180) 2",
                            ball_pos_x, ball_pos_y, game_state);
        end
        set_btns(0, 0, 0, 0, 0);
        ticks(49);
        total++;
        if (game_state !== 2'd2) begin
            bad++; $display("FAIL pause_length: got st=%0d want 2 after 59 frames", game_state);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y, game_state} !== {10'd315, 10'd235, 2'd1}) begin
            bad++; $display("FAIL recentre: got (%0d,%0d) st=%0d want (315,235) 1",
                            ball_pos_x, ball_pos_y, game_state);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd313, 10'd237}) begin
            bad++; $display("FAIL serve_toward_loser: got (%0d,%0d) want (313,237)", ball_pos_x, ball_pos_y);
        end
    endtask

    // Nine right-side misses with paddle1 parked at 200; odd rounds mirror round 1, even round 2.
    task automatic test_game_over();
        do_reset();
        set_btns(0, 0, 0, 0, 1);
        ticks(1);
        set_btns(0, 0, 0, 0, 0);
        ticks(158);
        total++;
        if ({ball_pos_x, ball_pos_y, score0, game_state} !== {10'd630, 10'd390, 4'd1, 2'd2}) begin
            bad++; $display("FAIL right_goal: got (%0d,%0d) s0=%0d st=%0d want (630,390) 1 2",
                            ball_pos_x, ball_pos_y, score0, game_state);
        end
        ticks(60);
        ticks(117);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd549, 10'd1}) begin
            bad++; $display("FAIL before_top: got (%0d,%0d) want (549,1)", ball_pos_x, ball_pos_y);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd551, 10'd0}) begin
            bad++; $display("FAIL top_clamp: got (%0d,%0d) want (551,0)", ball_pos_x, ball_pos_y);
        end
        ticks(1);
        total++;
        if ({ball_pos_x, ball_pos_y} !== {10'd553, 10'd2}) begin
            bad++; $display("FAIL top_rebound: got (%0d,%0d) want (553,2)", ball_pos_x, ball_pos_y);
        end
        ticks(39);
        total++;
        if ({ball_pos_x, ball_pos_y, score0} !== {10'd630, 10'd80, 4'd2}) begin
            bad++; $display("FAIL second_goal: got (%0d,%0d) s0=%0d want (630,80) 2",
                            ball_pos_x, ball_pos_y, score0);
        end
        ticks(60);
        for (int r = 3; r <= 8; r++) begin
            ticks(158);
            total++;
            if ({score0, score1, game_state} !== {4'(r), 4'd0, 2'd2}) begin
                bad++; $display("FAIL round_%0d_goal: got s=%0d/%0d st=%0d want %0d/0 2",
                                r, score0, score1, game_state, r);
            end
            ticks(60);
        end
        ticks(158);
        ticks(59);
        total++;
        if ({ball_pos_x, ball_pos_y, score0, game_state} !== {10'd630, 10'd390, 4'd9, 2'd2}) begin
            bad++; $display("FAIL winning_goal_pause: got (%0d,%0d) s0=%0d st=%0d want (630,390) 9 2",
                            ball_pos_x, ball_pos_y, score0, game_state);
        end
        ticks(1);
        ticks(3);
        total++;
        if ({ball_pos_x, ball_pos_y, score0, score1, game_state} !== {10'd315, 10'd235, 4'd9, 4'd0, 2'd3}) begin
            bad++; $display("FAIL game_over: got (%0d,%0d) s=%0d/%0d st=%0d want (315,235) 9/0 3",
                            ball_pos_x, ball_pos_y, score0, score1, game_state);
        end
        set_btns(0, 0, 0, 0, 1);
        ticks(1);
        total++;
        if ({score0, score1, game_state} !== {4'd0, 4'd0, 2'd0}) begin
            bad++; $display("FAIL restart: got s=%0d/%0d st=%0d want 0/0 0", score0, score1, game_state);
        end
        set_btns(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_midframe();
        set_btns(0, 0, 0, 0, 1);
        ticks(1);
        set_btns(1, 0, 0, 0, 0);
        ticks(10);
        total++;
        if ({paddle0_pos, ball_pos_x, ball_pos_y, game_state} !== {10'd160, 10'd335, 10'd215, 2'd1}) begin
            bad++; $display("FAIL replay_serve: got p0=%0d (%0d,%0d) st=%0d want 160 (335,215) 1",
                            paddle0_pos, ball_pos_x, ball_pos_y, game_state);
        end
        set_btns(0, 0, 0, 0, 0);
        @(negedge clk_pxl);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y, score0, score1, game_state}
            !== {10'd200, 10'd200, 10'd315, 10'd235, 4'd0, 4'd0, 2'd0}) begin
            bad++;
            $display("FAIL async_reset: got p0=%0d p1=%0d x=%0d y=%0d s=%0d/%0d st=%0d want 200 200 315 235 0/0 0",
                     paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y, score0, score1, game_state);
        end
        @(negedge clk_pxl);
        reset = 1'b0;
        ticks(2);
        total++;
        if ({ball_pos_x, ball_pos_y, game_state} !== {10'd315, 10'd235, 2'd0}) begin
            bad++; $display("FAIL after_reset_serve: got (%0d,%0d) st=%0d want (315,235) 0",
                            ball_pos_x, ball_pos_y, game_state);
        end
    endtask

    initial begin
        test_reset();
        test_paddle_clamp();
        test_paddle_bounce();
        test_miss();
        test_game_over();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_game_logic.md
# pong_game_logic

Frame-rate game engine for the Pong VGA design, sitting directly upstream of the VGA driver's RGB drawer. It samples the player buttons, moves both paddles and the ball once per video frame, detects wall, paddle and goal collisions, and keeps score. Its registered position outputs replace the constant paddle and ball positions currently tied off in the VGA top level.

## Interface
- H_ACTIVE, 640: visible pixels per line
- V_ACTIVE, 480: visible lines
- PADDLE_H, 80: paddle height (px)
- PADDLE_W, 10: paddle width (px)
- PADDLE_X0, 20: left edge of paddle 0
- PADDLE_X1, 610: left edge of paddle 1
- BALL_SIZE, 10: ball side (px), square
- PADDLE_SPEED, 4: px per frame
- BALL_SPEED, 2: px per frame, each axis
- SCORE_PAUSE, 60: frames the ball is frozen after a point
- WIN_SCORE, 9: score that ends the game

- clk_pxl  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- btn_up0, btn_dn0, btn_up1, btn_dn1  in  1 each  raw asynchronous paddle buttons
- btn_start  in  1  raw asynchronous serve/restart button
- paddle0_pos, paddle1_pos  out  10  paddle top y
- ball_pos_x, ball_pos_y  out  10  ball top-left
- score0, score1  out  4  points won
- game_state  out  2  SERVE=0, PLAY=1, SCORED=2, GAME_OVER=3

## Operation
- Reset values: paddles 200, ball (315, 235), scores 0, state SERVE, ball direction dx=+, dy=+, pause counter 0.
- All state updates occur only on cycles where frame_tick=1. Otherwise every register holds.
- Paddles move in every state. If up=1 and down=0, pos = max(pos-PADDLE_SPEED, 0). If down=1 and up=0, pos = min(pos+PADDLE_SPEED, V_ACTIVE-PADDLE_H). If both or neither are pressed, the paddle holds.
- Arithmetic is done at 11 bits, so values never wrap, then clamped into 10 bits.
- SERVE: ball held at centre. A synchronized btn_start moves the state to PLAY.
- PLAY: the candidate step is nx = x ± BALL_SPEED, ny = y ± BALL_SPEED. Checks apply in priority order:
  - Vertical, if ny < 0: y=0, dy=+.
  - Vertical, if ny+BALL_SIZE > V_ACTIVE: y=V_ACTIVE-BALL_SIZE, dy=-.
  - Horizontal, left paddle: dx=-, x ≥ PADDLE_X0+PADDLE_W, nx ≤ PADDLE_X0+PADDLE_W, and vertical overlap (y+BALL_SIZE > paddle0_pos and y < paddle0_pos+PADDLE_H). Then x=PADDLE_X0+PADDLE_W, dx=+.
  - Horizontal, right paddle: the mirror check against PADDLE_X1. Then x=PADDLE_X1-BALL_SIZE, dx=-.
  - Goal, if nx < 0: x=0, score1++, enter SCORED, loser=0.
  - Goal, if nx+BALL_SIZE > H_ACTIVE: x=H_ACTIVE-BALL_SIZE, score0++, enter SCORED, loser=1.
  - Otherwise the candidate step is accepted.
- Collision checks use the paddle positions from before this frame's paddle update.
- A vertical bounce and a horizontal event in the same frame are both applied.
- SCORED: the ball stays frozen at the edge and the pause counter counts frames. After SCORE_PAUSE frames:
  - If either score equals WIN_SCORE, go to GAME_OVER.
  - Otherwise, recentre the ball, set dx toward the loser, keep dy, and go to PLAY.
- GAME_OVER: ball held at centre and scores held. btn_start clears the scores and goes to SERVE.
- btn_start is ignored in PLAY and SCORED.

## Timing
- Each button passes through a 2-flop synchronizer, giving 2 cycles of latency before it is sampled.
- A button must be synchronized-high on the frame_tick cycle to take effect.
- All outputs are registered. They change on the clk_pxl edge that samples frame_tick=1 and are stable for the rest of the frame, including the whole active region.
- Latency from frame_tick to updated outputs: 1 cycle.
- Back-to-back frame_tick pulses are legal; each one is a full update.
- Reset asserted mid-frame returns all outputs to their reset values immediately (asynchronous). Updates resume on the first frame_tick after reset is released.

## Structure
- Package pong_pkg holds:
  - the game_state encoding;
  - the 11-bit working width;
  - the reset/centre constants (centre x = (H_ACTIVE-BALL_SIZE)/2, y = (V_ACTIVE-BALL_SIZE)/2, paddle = (V_ACTIVE-PADDLE_H)/2).
- Sub-module btn_sync: a single-bit 2-flop synchronizer with asynchronous reset to 0, instantiated 5 times.
- Paddle update logic is one shared function applied to both paddles.

## Test plan
- Reset, then 3 frame_ticks with no buttons: paddles stay 200, ball stays (315,235), state SERVE.
- Paddle clamp: hold btn_up0 for 60 frames, then paddle0_pos=0 and holds. Hold btn_dn1 for 60 frames, then paddle1_pos=400. Both buttons on paddle 0 pressed: paddle 0 does not move.
- Paddle bounce:
  - Setup: start, ball heading left, paddle0 covering the ball's y.
  - Required response: the ball reaches x=30, dx flips to +, and on the next frame x=32.
- Miss:
  - Setup: paddle0 at 0, ball at y≈235 heading left.
  - Required response: the ball reaches x=0 and score1=1, with state SCORED for 60 frames.
  - Then the ball recentres at (315,235) with dx=-.
- Top wall bounce: ball at y=1 with dy=-, then y=0 and dy=+, and y=2 on the next frame.
- Game over: preload scores 8/0 and force a right-side miss. score0=9, and after the pause the state is GAME_OVER. btn_start then gives scores 0/0 and state SERVE. Assert reset mid-frame: all outputs at reset values within 0 cycles.
